bp_mem_1rw_arbiter: RTL and testbench

Shares one single-port (1RW), byte-masked SRAM wrapper (default 512x64) among num_req_p requesters. Arbitration is round-robin. The block drives the SRAM's v/w/addr/data/write_mask pins and routes read data back to the winning requester one cycle after the grant. It sits between cache/tag-engine request sources and the hardened memory wrapper instance.

---
 rtl/bp_mem_1rw_arbiter.sv | 133 +++++++++++++
 tb/tb_bp_mem_1rw_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_mem_1rw_arbiter.sv
// Round-robin arbiter sharing one 1RW byte-masked SRAM among num_req_p requesters.
// Optional zero-fill sequence after reset: define BP_MEM_1RW_ARBITER_INIT_EN.
module bp_mem_1rw_arbiter #(
    parameter int num_req_p = 2,
    parameter int width_p   = 64,
    parameter int els_p     = 512,
    localparam int addr_width_lp   = $clog2(els_p),
    localparam int mask_width_lp   = width_p >> 3,
    localparam int req_id_width_lp = $clog2(num_req_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [num_req_p-1:0]                 v_i,
    input  logic [num_req_p-1:0]                 w_i,
    input  logic [num_req_p*addr_width_lp-1:0]   addr_i,
    input  logic [num_req_p*width_p-1:0]         data_i,
    input  logic [num_req_p*mask_width_lp-1:0]   write_mask_i,
    output logic [num_req_p-1:0]                 yumi_o,
    output logic [num_req_p-1:0]                 data_v_o,
    output logic [width_p-1:0]                   data_o,
    output logic                                 busy_o,
    output logic                                 mem_v_o,
    output logic                                 mem_w_o,
    output logic [addr_width_lp-1:0]             mem_addr_o,
    output logic [width_p-1:0]                   mem_data_o,
    output logic [mask_width_lp-1:0]             mem_write_mask_o,
    input  logic [width_p-1:0]                   mem_data_i
);

    logic [num_req_p-1:0][addr_width_lp-1:0] addr_a;
    logic [num_req_p-1:0][width_p-1:0]       data_a;
    logic [num_req_p-1:0][mask_width_lp-1:0] mask_a;

    assign addr_a = addr_i;
    assign data_a = data_i;
    assign mask_a = write_mask_i;

    logic [req_id_width_lp-1:0] rr_ptr;
    logic [req_id_width_lp-1:0] grant_id;
    logic [req_id_width_lp-1:0] cand;
    logic                       grant_found;
    logic                       arb_en;
    logic                       rd_pending;
    logic [req_id_width_lp-1:0] rd_id;
    int unsigned                idx;

`ifdef BP_MEM_1RW_ARBITER_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_e;
    state_e                   state;
    logic [addr_width_lp-1:0] init_addr;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else if (state == ST_INIT) begin
            if (init_addr == addr_width_lp'(els_p - 1)) begin
                state <= ST_RUN;
            end else begin
                init_addr <= init_addr + 1'b1;
            end
        end
    end

    assign busy_o = (state == ST_INIT);
    assign arb_en = reset_n_i & (state == ST_RUN);
`else
    assign busy_o = 1'b0;
    assign arb_en = reset_n_i;
`endif

    // Search from rr_ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        cand        = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            cand = req_id_width_lp'(idx);
            if (!grant_found && v_i[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        yumi_o = '0;
        if (grant_found && arb_en) yumi_o[grant_id] = 1'b1;
    end

    // With no grant, grant_id is 0 so the pins follow requester 0.
    always_comb begin
        mem_v_o          = |yumi_o;
        mem_w_o          = w_i[grant_id];
        mem_addr_o       = addr_a[grant_id];
        mem_data_o       = data_a[grant_id];
        mem_write_mask_o = mask_a[grant_id];
`ifdef BP_MEM_1RW_ARBITER_INIT_EN
        if (state == ST_INIT) begin
            mem_v_o          = reset_n_i;
            mem_w_o          = 1'b1;
            mem_addr_o       = init_addr;
            mem_data_o       = '0;
            mem_write_mask_o = '1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr     <= '0;
            rd_pending <= 1'b0;
            rd_id      <= '0;
        end else begin
            if (|yumi_o) begin
                rr_ptr <= (grant_id == req_id_width_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
            end
            rd_pending <= (|yumi_o) & ~w_i[grant_id];
            rd_id      <= grant_id;
        end
    end

    always_comb begin
        data_v_o = '0;
        if (rd_pending) data_v_o[rd_id] = 1'b1;
    end

    assign data_o = mem_data_i;

endmodule

// File: tb/tb_bp_mem_1rw_arbiter.sv
// Directed bench for bp_mem_1rw_arbiter with a behavioural 512x64 byte-masked 1RW SRAM.
module tb_bp_mem_1rw_arbiter;
    localparam int N  = 2;
    localparam int W  = 64;
    localparam int E  = 512;
    localparam int AW = 9;
    localparam int MW = 8;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [N-1:0]    v_i, w_i;
    logic [N*AW-1:0] addr_i;
    logic [N*W-1:0]  data_i;
    logic [N*MW-1:0] write_mask_i;
    logic [N-1:0]    yumi_o, data_v_o;
    logic [W-1:0]    data_o;
    logic            busy_o, mem_v_o, mem_w_o;
    logic [AW-1:0]   mem_addr_o;
    logic [W-1:0]    mem_data_o, mem_data_i;
    logic [MW-1:0]   mem_write_mask_o;

    int total = 0;
    int bad   = 0;

    bp_mem_1rw_arbiter #(.num_req_p(N), .width_p(W), .els_p(E)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .w_i(w_i),
        .addr_i(addr_i), .data_i(data_i), .write_mask_i(write_mask_i),
        .yumi_o(yumi_o), .data_v_o(data_v_o), .data_o(data_o), .busy_o(busy_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_write_mask_o(mem_write_mask_o),
        .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    logic [W-1:0] mem [E];
    logic [W-1:0] rd_q;
    assign mem_data_i = rd_q;

    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int j = 0; j < MW; j++)
                    if (mem_write_mask_o[j]) mem[mem_addr_o][j*8 +: 8] <= mem_data_o[j*8 +: 8];
            end else begin
                rd_q <= mem[mem_addr_o];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic setreq(input int k, input logic v, input logic w, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic [MW-1:0] m);
        v_i[k]                  = v;
        w_i[k]                  = w;
        addr_i[k*AW +: AW]      = a;
        data_i[k*W +: W]        = d;
        write_mask_i[k*MW +: MW] = m;
    endtask

    task automatic wait_init();
`ifdef BP_MEM_1RW_ARBITER_INIT_EN
        int n = 0;
        while (busy_o && n < 600) begin
            @(negedge clk_i);
            n++;
        end
        check("init_timeout", 64'(busy_o), 64'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < E; i++) mem[i] = 64'hA5A5_A5A5_A5A5_A5A5;
        reset_n_i = 1'b0;
        v_i = '0; w_i = '0; addr_i = '0; data_i = '0; write_mask_i = '0;

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_yumi", 64'(yumi_o), 64'd0);
        check("rst_data_v", 64'(data_v_o), 64'd0);
        check("rst_mem_v", 64'(mem_v_o), 64'd0);
`ifdef BP_MEM_1RW_ARBITER_INIT_EN
        check("rst_busy", 64'(busy_o), 64'd1);
`else
        check("rst_busy", 64'(busy_o), 64'd0);
`endif
        @(negedge clk_i);
        reset_n_i = 1'b1;

`ifdef BP_MEM_1RW_ARBITER_INIT_EN
        begin
            int n = 0;
            setreq(0, 1, 0, 0, '0, '0);
            setreq(1, 1, 0, 0, '0, '0);
            #1;
            while (busy_o && n < 600) begin
                check("init_addr", 64'(mem_addr_o), 64'(n));
                check("init_yumi", 64'(yumi_o), 64'd0);
                n++;
                @(posedge clk_i);
                @(negedge clk_i);
                #1;
            end
            check("init_cycles", 64'(n), 64'd512);
            setreq(1, 0, 0, 0, '0, '0);
            @(negedge clk_i);
            setreq(0, 1, 0, 300, '0, '0);
            #1 check("init_rd_yumi", 64'(yumi_o), 64'd1);
            @(posedge clk_i);
            #1 check("init_rd_data", data_o, 64'd0);
            @(negedge clk_i);
            setreq(0, 0, 0, 0, '0, '0);
        end
`endif

        // Single requester write then read.
        @(negedge clk_i);
        setreq(0, 1, 1, 5, 64'h1122334455667788, 8'hFF);
        #1;
        check("t1_wr_yumi", 64'(yumi_o), 64'd1);
        check("t1_wr_mem_w", 64'(mem_w_o), 64'd1);
        check("t1_wr_addr", 64'(mem_addr_o), 64'd5);
        @(negedge clk_i);
        setreq(0, 1, 0, 5, '0, '0);
        #1;
        check("t1_rd_yumi", 64'(yumi_o), 64'd1);
        check("t1_rd_mem_w", 64'(mem_w_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("t1_data_v", 64'(data_v_o), 64'd1);
        check("t1_data", data_o, 64'h1122334455667788);
        @(negedge clk_i);
        setreq(0, 0, 0, 0, '0, '0);

        // Byte mask.
        @(negedge clk_i);
        setreq(0, 1, 1, 9, '1, 8'hFF);
        @(negedge clk_i);
        setreq(0, 1, 1, 9, '0, 8'h0F);
        #1 check("t2_mask_pin", 64'(mem_write_mask_o), 64'h0F);
        @(negedge clk_i);
        setreq(0, 1, 0, 9, '0, '0);
        @(posedge clk_i);
        #1;
        check("t2_data_v", 64'(data_v_o), 64'd1);
        check("t2_data", data_o, 64'hFFFFFFFF00000000);
        @(negedge clk_i);
        setreq(0, 0, 0, 0, '0, '0);

        // Contention: preload, then both read continuously.
        @(negedge clk_i);
        setreq(0, 1, 1, 1, 64'hA1, 8'hFF);
        @(negedge clk_i);
        setreq(0, 0, 0, 0, '0, '0);
        setreq(1, 1, 1, 2, 64'hB2, 8'hFF);
        @(negedge clk_i);
        setreq(0, 1, 0, 1, '0, '0);
        setreq(1, 1, 0, 2, '0, '0);
        for (int c = 0; c < 6; c++) begin
            #1 check("t3_yumi", 64'(yumi_o), (c % 2 == 0) ? 64'd1 : 64'd2);
            @(posedge clk_i);
            #1;
            check("t3_data_v", 64'(data_v_o), (c % 2 == 0) ? 64'd1 : 64'd2);
            check("t3_data", data_o, (c % 2 == 0) ? 64'hA1 : 64'hB2);
            @(negedge clk_i);
        end

        // Fairness after a lone req1 grant, and pointer hold across idle.
        setreq(0, 0, 0, 1, '0, '0);
        #1 check("t4_lone1", 64'(yumi_o), 64'd2);
        @(negedge clk_i);
        setreq(0, 1, 0, 1, '0, '0);
        #1 check("t4_both", 64'(yumi_o), 64'd1);
        @(negedge clk_i);
        setreq(0, 0, 0, 7, '0, '0);
        setreq(1, 0, 0, 3, '0, '0);
        #1;
        check("t4_idle_addr", 64'(mem_addr_o), 64'd7);
        check("t4_idle_mem_v", 64'(mem_v_o), 64'd0);
        @(negedge clk_i);
        setreq(0, 1, 0, 1, '0, '0);
        setreq(1, 1, 0, 2, '0, '0);
        #1 check("t4_hold_ptr", 64'(yumi_o), 64'd2);

        // Async reset right after a read grant.
        @(negedge clk_i);
        setreq(1, 0, 0, 2, '0, '0);
        #1 check("t5_pre_yumi", 64'(yumi_o), 64'd1);
        @(posedge clk_i);
        #3 reset_n_i = 1'b0;
        #1;
        check("t5_data_v", 64'(data_v_o), 64'd0);
        check("t5_mem_v", 64'(mem_v_o), 64'd0);
        check("t5_yumi", 64'(yumi_o), 64'd0);
        @(negedge clk_i);
        setreq(1, 1, 0, 2, '0, '0);
        reset_n_i = 1'b1;
        wait_init();
        #1 check("t5_first_win", 64'(yumi_o), 64'd1);
        @(negedge clk_i);
        setreq(0, 0, 0, 0, '0, '0);
        setreq(1, 0, 0, 0, '0, '0);
        repeat (2) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
